// File: rtl/fifo_mst_write_gen.sv
// FT60x 245-synchronous-FIFO master write traffic generator.
// Streams fixed-length write bursts with a selectable data pattern. Every
// beat is held until the FT60x accepts it, so TXE_N stalls never drop data.
// A finite run can end with a one-cycle SIWU_N pulse to flush a short packet.
module fifo_mst_write_gen #(
  parameter int DATA_W     = 16,
  parameter int BURST_LEN  = 512,
  parameter int GAP_CYCLES = 2
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  EN,
  input  logic [1:0]            MODE,
  input  logic [DATA_W-1:0]     SEED,
  input  logic [15:0]           NUM_BURSTS,
  input  logic                  SIWU_EN,
  input  logic                  TXE_N,
  input  logic                  RXF_N,
  output logic                  WR_N,
  output logic                  RD_N,
  output logic                  OE_N,
  output logic                  SIWU_N,
  output logic [DATA_W/8-1:0]   BE,
  output logic [DATA_W-1:0]     DATA,
  output logic                  BUSY,
  output logic                  DONE,
  output logic [15:0]           BURST_CNT,
  output logic [15:0]           STALL_CNT
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WAIT  = 3'd1;
  localparam logic [2:0] S_BURST = 3'd2;
  localparam logic [2:0] S_GAP   = 3'd3;
  localparam logic [2:0] S_FLUSH = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam int TAG_W = DATA_W - 8;

  logic [2:0]        r_state;
  logic              r_wr_n;
  logic              r_siwu_n;
  logic [DATA_W-1:0] r_data;
  logic [DATA_W-1:0] r_seed;
  logic [1:0]        r_mode;
  logic [15:0]       r_beat;
  logic [15:0]       r_bcnt;
  logic [15:0]       r_stall;
  logic [7:0]        r_gap;

  logic [2:0]        w_nxt;
  logic [7:0]        w_gap_nxt;
  logic              w_acc;
  logic              w_last;
  logic              w_fin;
  logic [15:0]       w_beat_nxt;
  logic [15:0]       w_bcnt_nxt;
  logic [DATA_W-1:0] w_pat;
  logic [DATA_W-1:0] w_start;
  logic [TAG_W-1:0]  w_tag_lo;
  logic              w_unused;

  // The read side of the FIFO bus is never used by this generator.
  assign w_unused  = RXF_N;
  assign RD_N      = 1'b1;
  assign OE_N      = 1'b1;
  assign BE        = '1;
  assign WR_N      = r_wr_n;
  assign SIWU_N    = r_siwu_n;
  assign DATA      = r_data;
  assign BURST_CNT = r_bcnt;
  assign STALL_CNT = r_stall;
  assign BUSY      = (r_state != S_IDLE) && (r_state != S_DONE);
  assign DONE      = (r_state == S_DONE);

  // WR_N is low only in BURST, so a low strobe plus free space is an accept.
  assign w_acc      = ~r_wr_n & ~TXE_N;
  assign w_last     = w_acc && (r_beat == 16'(BURST_LEN - 1));
  assign w_fin      = (NUM_BURSTS != 16'd0) && ((r_bcnt + 16'd1) == NUM_BURSTS);
  assign w_beat_nxt = w_last ? 16'd0 : r_beat + 16'd1;
  assign w_bcnt_nxt = w_last ? r_bcnt + 16'd1 : r_bcnt;

  // Low tag field carries the beat index, zero-extended on wide buses.
  if (TAG_W <= 16) begin : g_tag_narrow
    assign w_tag_lo = w_beat_nxt[TAG_W-1:0];
  end else begin : g_tag_wide
    assign w_tag_lo = {{(TAG_W-16){1'b0}}, w_beat_nxt};
  end

  // Next pattern value, applied only on an accepted beat.
  always_comb begin
    w_pat = r_data;
    case (r_mode)
      2'd0:    w_pat = r_data + DATA_W'(1);
      2'd1:    w_pat = {r_data[DATA_W-2:0], r_data[DATA_W-1]};
      2'd2:    w_pat = r_seed;
      default: w_pat = {w_bcnt_nxt[7:0], w_tag_lo};
    endcase
  end

  // First beat of a run, taken from the live MODE/SEED at run start.
  always_comb begin
    w_start = '0;
    case (MODE)
      2'd0:    w_start = SEED;
      2'd1:    w_start = DATA_W'(1);
      2'd2:    w_start = SEED;
      default: w_start = '0;
    endcase
  end

  // Run-control state machine; EN is deliberately ignored inside BURST.
  always_comb begin
    w_nxt     = r_state;
    w_gap_nxt = r_gap;
    case (r_state)
      S_IDLE:  if (EN) w_nxt = S_WAIT;
      S_WAIT: begin
        if (!EN)         w_nxt = S_IDLE;
        else if (!TXE_N) w_nxt = S_BURST;
      end
      S_BURST: begin
        if (w_last) begin
          w_gap_nxt = 8'd0;
          if (w_fin && SIWU_EN)  w_nxt = S_FLUSH;
          else if (w_fin)        w_nxt = S_DONE;
          else if (GAP_CYCLES == 0) w_nxt = S_WAIT;
          else                   w_nxt = S_GAP;
        end
      end
      S_GAP: begin
        if (!EN)                                w_nxt = S_IDLE;
        else if (r_gap == 8'(GAP_CYCLES - 1))   w_nxt = S_WAIT;
        else                                    w_gap_nxt = r_gap + 8'd1;
      end
      S_FLUSH: w_nxt = S_DONE;
      S_DONE:  if (!EN) w_nxt = S_IDLE;
      default: w_nxt = S_IDLE;
    endcase
  end

  // State and bus strobes; strobes follow the next state so they are glitch-free.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state  <= S_IDLE;
      r_wr_n   <= 1'b1;
      r_siwu_n <= 1'b1;
      r_gap    <= 8'd0;
    end else begin
      r_state  <= w_nxt;
      r_wr_n   <= (w_nxt != S_BURST);
      r_siwu_n <= (w_nxt != S_FLUSH);
      r_gap    <= w_gap_nxt;
    end
  end

  // Data path and counters: load at run start, advance only on accepted beats.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_data  <= '0;
      r_seed  <= '0;
      r_mode  <= 2'd0;
      r_beat  <= 16'd0;
      r_bcnt  <= 16'd0;
      r_stall <= 16'd0;
    end else begin
      if (r_state == S_IDLE && EN) begin
        r_mode  <= MODE;
        r_seed  <= SEED;
        r_data  <= w_start;
        r_beat  <= 16'd0;
        r_bcnt  <= 16'd0;
        r_stall <= 16'd0;
      end else begin
        if (w_acc) begin
          r_data <= w_pat;
          r_beat <= w_beat_nxt;
          r_bcnt <= w_bcnt_nxt;
        end
        if (r_state == S_BURST && TXE_N && r_stall != 16'hFFFF)
          r_stall <= r_stall + 16'd1;
      end
    end
  end

endmodule

// File: doc/fifo_mst_write_gen.md
# fifo_mst_write_gen

Parametrised FT60x 245-synchronous-FIFO master write traffic generator for FPGA-to-host data-stream bring-up and throughput testing. Sits between the FT60x FIFO bus pins and a small control/status interface. Streams fixed-length write bursts with a selectable data pattern, and never loses a beat when TXE_N drops mid-burst. Optionally flushes the final short packet with SIWU_N.

## Interface
Parameters:
- DATA_W, 16, FIFO bus width: 16 (FT600) or 32 (FT601).
- BURST_LEN, 512, accepted beats per burst, 1..65535.
- GAP_CYCLES, 2, idle cycles between bursts, 0..255.

Ports:
- CLK  in  1  FT60x bus clock; single clock domain.
- RESET  in  1  synchronous, active-high reset.
- EN  in  1  run enable; a rising level in IDLE starts a run.
- MODE  in  2  pattern: 0 incrementing, 1 walking-one, 2 constant SEED, 3 tagged.
- SEED  in  DATA_W  constant value for mode 2 and start value for mode 0.
- NUM_BURSTS  in  16  bursts per run; 0 means unlimited.
- SIWU_EN  in  1  pulse SIWU_N when a finite run completes.
- TXE_N  in  1  FT60x transmit FIFO has space when low.
- RXF_N  in  1  ignored.
- WR_N  out  1  write strobe, active low, registered.
- RD_N  out  1  constant 1.
- OE_N  out  1  constant 1.
- SIWU_N  out  1  send-immediate, active low, registered.
- BE  out  DATA_W/8  constant all ones.
- DATA  out  DATA_W  write data, registered.
- BUSY  out  1  high in any state except IDLE and DONE.
- DONE  out  1  high in DONE.
- BURST_CNT  out  16  completed bursts this run.
- STALL_CNT  out  16  saturating count of BURST cycles with TXE_N high.

## Operation
- Reset values: WR_N=1, SIWU_N=1, RD_N=1, OE_N=1, BE all ones, DATA=0, BUSY=0, DONE=0, BURST_CNT=0, STALL_CNT=0, state IDLE.
- Accept rule: a beat is accepted on a CLK edge where registered WR_N==0 and TXE_N==0. DATA advances only on accepted beats, otherwise it holds.
- States:
  - IDLE: if EN, go to WAIT; load the pattern start value; clear BURST_CNT, STALL_CNT and the beat counter.
  - WAIT: WR_N=1. If EN is low, go to IDLE. If TXE_N is low, go to BURST.
  - BURST: WR_N=0. Beat counter counts accepted beats. When the accepted beat count reaches BURST_LEN, increment BURST_CNT, clear the beat counter and exit:
    - to FLUSH if NUM_BURSTS≠0, BURST_CNT+1==NUM_BURSTS and SIWU_EN;
    - else to DONE if the run is finite and complete;
    - else to GAP, or to WAIT if GAP_CYCLES==0.
  - EN is ignored inside BURST; a started burst always completes.
  - GAP: WR_N=1 for GAP_CYCLES cycles, then go to WAIT. EN low goes to IDLE immediately.
  - FLUSH: SIWU_N=0 for exactly one cycle, then go to DONE.
  - DONE: WR_N=1. Stay while EN is high; go to IDLE when EN is low.
- Patterns advance per accepted beat, modulo 2^DATA_W:
  - Mode 0: SEED, SEED+1, ... continuous across bursts within a run.
  - Mode 1: 1, 2, 4, ... rotating left, wrapping the MSB back to bit 0.
  - Mode 2: SEED on every beat.
  - Mode 3: {BURST_CNT[7:0], beat index[DATA_W-9:0]}.
- MODE and SEED are sampled at IDLE→WAIT and held for the whole run.
- BURST_CNT wraps at 2^16 in unlimited mode. STALL_CNT saturates at 0xFFFF.

## Timing
- EN high in IDLE: WAIT one cycle later. With TXE_N low, WR_N falls 2 cycles after EN is sampled.
- DATA valid with WR_N. The next value appears the cycle after each accept.
- WR_N is registered from the next state, so it rises in the cycle after the final accepting edge. No extra beat is presented.
- TXE_N high mid-burst: WR_N stays low, DATA holds, STALL_CNT increments each cycle. Streaming resumes on the first edge with TXE_N low.
- Burst-to-burst spacing with continuous TXE_N low is BURST_LEN + GAP_CYCLES + 1 cycles (the +1 is the WAIT cycle).
- RESET mid-burst: all outputs take their reset values at the next edge; the partial burst is abandoned.

## Test plan
- DATA_W=16, BURST_LEN=8, GAP=2, MODE0, SEED=0xFFFE, NUM_BURSTS=2, TXE_N low: DATA FFFE,FFFF,0000..0005, then 0006..000D. WR_N high 3 cycles between bursts. DONE=1, BURST_CNT=2.
- Same setup, TXE_N high for 3 cycles after beat 4: WR_N stays low, DATA holds 0x0002 (4th beat), STALL_CNT=3, exactly 8 beats accepted per burst.
- DATA_W=32, MODE1, BURST_LEN=40: beats 0..31 = 1<<i, beat 32 = 0x00000001.
- NUM_BURSTS=1, SIWU_EN=1: single SIWU_N low pulse the cycle after WR_N rises, then DONE. SIWU_EN=0 gives no pulse.
- EN low during BURST: burst completes all BURST_LEN beats, then GAP→IDLE. RESET asserted mid-burst: WR_N=1, DATA=0, BURST_CNT=0 next cycle.
- MODE3, BURST_LEN=4, NUM_BURSTS=0: burst 2 data = 0x0200..0x0203 (16-bit), run continues unbounded.
